// File: rtl/coasia_pkg.sv
// Shared types and field widths for the coasia scheduler.
package coasia_pkg;

  localparam int unsigned MEMS_W = 3;
  localparam int unsigned LANG_W = 2;

  typedef enum logic [1:0] {
    ApprNone     = 2'b00,
    ApprApproved = 2'b01,
    ApprRejected = 2'b10,
    ApprError    = 2'b11
  } approval_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } sched_state_e;

endpackage

// File: rtl/coasia_rr_arb.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module coasia_rr_arb
  import coasia_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      logic [IDX_W:0] pos;
      pos = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
        pos = pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[pos[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/coasia_sched.sv
// Round-robin scheduler sharing one application evaluator between NUM_REQ requesters.
// Define COASIA_SCHED_STATS_EN to add the stat_done / stat_tmo saturating counters.
module coasia_sched
  import coasia_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned TMO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*MEMS_W-1:0]   req_mems,
  input  logic [NUM_REQ*LANG_W-1:0]   req_lang_cer,
  input  logic [NUM_REQ-1:0]          req_kore_sub,
  output logic [NUM_REQ-1:0]          ack,
  output logic [1:0]                  ack_approval,
  output logic                        ev_valid,
  output logic [MEMS_W-1:0]           mems,
  output logic [LANG_W-1:0]           lang_cer,
  output logic                        kore_sub,
  input  logic [1:0]                  approval
`ifdef COASIA_SCHED_STATS_EN
  ,
  output logic [15:0]                 stat_done,
  output logic [15:0]                 stat_tmo
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [MEMS_W-1:0] mems_q, mems_d;
  logic [LANG_W-1:0] lang_q, lang_d;
  logic              kore_q, kore_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  approval_e         code_q, code_d;

  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic              cnt_last;

  coasia_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign cnt_last = (cnt_q == TMO_W'(TIMEOUT - 1));

  // Next-state and output decode for the issue/wait/respond sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    mems_d       = mems_q;
    lang_d       = lang_q;
    kore_d       = kore_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    ev_valid     = 1'b0;
    ack          = '0;
    ack_approval = ApprNone;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          win_d = gnt_idx;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == IDX_W'(i)) begin
              mems_d = req_mems[i*MEMS_W +: MEMS_W];
              lang_d = req_lang_cer[i*LANG_W +: LANG_W];
              kore_d = req_kore_sub[i];
            end
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        ev_valid = 1'b1;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + TMO_W'(1);
        // A real decision wins over a timeout landing in the same cycle.
        if (approval != ApprNone) begin
          code_d  = approval_e'(approval);
          state_d = StResp;
        end else if (cnt_last) begin
          code_d  = ApprError;
          state_d = StResp;
        end
      end
      StResp: begin
        ack[win_q]   = 1'b1;
        ack_approval = code_q;
        rr_ptr_d     = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched application registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      win_q    <= '0;
      mems_q   <= '0;
      lang_q   <= '0;
      kore_q   <= 1'b0;
      cnt_q    <= '0;
      code_q   <= ApprNone;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      mems_q   <= mems_d;
      lang_q   <= lang_d;
      kore_q   <= kore_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
    end
  end

  assign mems     = mems_q;
  assign lang_cer = lang_q;
  assign kore_sub = kore_q;

`ifdef COASIA_SCHED_STATS_EN
  logic [15:0] stat_done_q, stat_done_d;
  logic [15:0] stat_tmo_q, stat_tmo_d;
  logic        tmo_q, tmo_d;

  // Saturating counters; tmo_q remembers that the pending code came from our own timeout.
  always_comb begin
    stat_done_d = stat_done_q;
    stat_tmo_d  = stat_tmo_q;
    tmo_d       = tmo_q;
    if (state_q == StIssue) begin
      tmo_d = 1'b0;
    end
    if ((state_q == StWait) && (approval == ApprNone) && cnt_last) begin
      tmo_d = 1'b1;
    end
    if (state_q == StResp) begin
      if (stat_done_q != 16'hFFFF) stat_done_d = stat_done_q + 16'd1;
      if (tmo_q && (stat_tmo_q != 16'hFFFF)) stat_tmo_d = stat_tmo_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_tmo_q  <= '0;
      tmo_q       <= 1'b0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_tmo_q  <= stat_tmo_d;
      tmo_q       <= tmo_d;
    end
  end

  assign stat_done = stat_done_q;
  assign stat_tmo  = stat_tmo_q;
`endif

endmodule

// File: tb/tb_coasia_sched.sv
// Self-checking bench for coasia_sched: directed cases plus randomized transactions
// checked against a transaction-level model of grant order, latency and codes.
module tb_coasia_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_mems;
  logic [7:0]  req_lang_cer;
  logic [3:0]  req_kore_sub;
  logic [3:0]  ack;
  logic [1:0]  ack_approval;
  logic        ev_valid;
  logic [2:0]  mems;
  logic [1:0]  lang_cer;
  logic        kore_sub;
  logic [1:0]  approval;
`ifdef COASIA_SCHED_STATS_EN
  logic [15:0] stat_done;
  logic [15:0] stat_tmo;
`endif

  always #5 clk = ~clk;

  coasia_sched #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_mems     (req_mems),
    .req_lang_cer (req_lang_cer),
    .req_kore_sub (req_kore_sub),
    .ack          (ack),
    .ack_approval (ack_approval),
    .ev_valid     (ev_valid),
    .mems         (mems),
    .lang_cer     (lang_cer),
    .kore_sub     (kore_sub),
    .approval     (approval)
`ifdef COASIA_SCHED_STATS_EN
    ,
    .stat_done    (stat_done),
    .stat_tmo     (stat_tmo)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;
  int done_m = 0;
  int tmo_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, modulo NUM_REQ.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int idx;
      idx = (p + k) % int'(NUM_REQ);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic idle(input int n);
    req      = '0;
    approval = 2'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_ack", 32'(ack), 32'd0);
      check_eq("idle_ev_valid", 32'(ev_valid), 32'd0);
    end
  endtask

  // One transaction starting at a negedge inside an IDLE cycle, ending in the next IDLE cycle.
  // delay: WAIT-cycle index at which the evaluator answers; >= TIMEOUT means never.
  task automatic txn(input logic [3:0] reqv, input logic [11:0] fm, input logic [7:0] fl,
                     input logic [3:0] fk, input int delay, input logic [1:0] code,
                     input bit drop);
    int w;
    int last;
    logic [5:0] efld;
    logic [1:0] ecode;
    req          = reqv;
    req_mems     = fm;
    req_lang_cer = fl;
    req_kore_sub = fk;
    approval     = 2'($urandom_range(1, 3));
    w     = pick(reqv, ptr_m);
    efld  = {fm[w*3 +: 3], fl[w*2 +: 2], fk[w]};
    last  = (delay < int'(TIMEOUT)) ? delay : int'(TIMEOUT) - 1;
    ecode = (delay < int'(TIMEOUT)) ? code : 2'b11;

    @(negedge clk);
    check_eq("issue_ev_valid", 32'(ev_valid), 32'd1);
    check_eq("issue_ack", 32'(ack), 32'd0);
    check_eq("issue_fields", 32'({mems, lang_cer, kore_sub}), 32'(efld));
    approval = 2'($urandom_range(1, 3));

    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      check_eq("wait_ev_valid", 32'(ev_valid), 32'd0);
      check_eq("wait_ack", 32'(ack), 32'd0);
      check_eq("wait_fields", 32'({mems, lang_cer, kore_sub}), 32'(efld));
      if (k == 0) begin
        req_mems     = 12'($urandom);
        req_lang_cer = 8'($urandom);
        req_kore_sub = 4'($urandom);
        if (drop) begin
          req[w] = 1'b0;
          req_mems[w*3 +: 3] = 3'd0;
        end
      end
      approval = (k == delay) ? code : 2'b00;
    end

    @(negedge clk);
    check_eq("resp_ack", 32'(ack), 32'd1 << w);
    check_eq("resp_code", 32'(ack_approval), 32'(ecode));
    check_eq("resp_ev_valid", 32'(ev_valid), 32'd0);
    ptr_m = (w + 1) % int'(NUM_REQ);
    done_m++;
    if (delay >= int'(TIMEOUT)) tmo_m++;
    approval = 2'($urandom_range(1, 3));

    @(negedge clk);
    check_eq("post_ack", 32'(ack), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    req          = '0;
    req_mems     = '0;
    req_lang_cer = '0;
    req_kore_sub = '0;
    approval     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_ack_approval", 32'(ack_approval), 32'd0);
    check_eq("rst_ev_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_fields", 32'({mems, lang_cer, kore_sub}), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single request, answered on first WAIT cycle.
    txn(4'b0100, 12'h000 | (12'd5 << 6), 8'h00 | (8'd2 << 4), 4'b0100, 0, 2'b01, 1'b0);

    // Fairness with all requesting.
    ptr_m = ptr_m;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 12'($urandom), 8'($urandom), 4'($urandom),
          $urandom_range(0, 3), 2'b10, 1'b0);
    end
    idle(1);

    // Timeout, then decision on the last WAIT cycle.
    txn(4'b0001, 12'($urandom), 8'($urandom), 4'($urandom), int'(TIMEOUT) + 3, 2'b01, 1'b0);
`ifdef COASIA_SCHED_STATS_EN
    check_eq("stat_tmo_one", 32'(stat_tmo), 32'(tmo_m));
`endif
    txn(4'b0001, 12'($urandom), 8'($urandom), 4'($urandom), int'(TIMEOUT) - 1, 2'b01, 1'b0);

    // Request dropped and fields changed during WAIT.
    txn(4'b0010, 12'($urandom), 8'($urandom), 4'($urandom), 3, 2'b10, 1'b1);

    // Mid-transaction reset: grant index 2 (ptr now 2), then abort in WAIT.
    req      = 4'b0100;
    approval = 2'b00;
    @(negedge clk);
    check_eq("pre_rst_issue", 32'(ev_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    check_eq("mid_rst_ack_approval", 32'(ack_approval), 32'd0);
    check_eq("mid_rst_ev_valid", 32'(ev_valid), 32'd0);
    check_eq("mid_rst_fields", 32'({mems, lang_cer, kore_sub}), 32'd0);
    rst    = 1'b0;
    ptr_m  = 0;
    done_m = 0;
    tmo_m  = 0;
    idle(3);
    txn(4'b0110, 12'($urandom), 8'($urandom), 4'($urandom), 1, 2'b11, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 150; i++) begin
      txn(4'($urandom_range(1, 15)), 12'($urandom), 8'($urandom), 4'($urandom),
          $urandom_range(0, TIMEOUT + 1), 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

`ifdef COASIA_SCHED_STATS_EN
    check_eq("stat_done", 32'(stat_done), 32'(done_m));
    check_eq("stat_tmo", 32'(stat_tmo), 32'(tmo_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
